// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection and bubble insertion.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module id_ex_hazard_reg #(
    parameter int XLEN   = 64,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ext_stall,
    input  logic              ex_flush,
    input  logic              if_id_valid,
    input  logic [XLEN-1:0]   if_id_pc,
    input  logic [REG_AW-1:0] if_id_Rs1,
    input  logic [REG_AW-1:0] if_id_Rs2,
    input  logic [REG_AW-1:0] if_id_rd,
    input  logic              if_id_uses_rs1,
    input  logic              if_id_uses_rs2,
    input  logic              if_id_RegWrite,
    input  logic              if_id_MemRead,
    input  logic              if_id_MemWrite,
    input  logic              if_id_MemtoReg,
    input  logic              if_id_Branch,
    input  logic              if_id_ALUSrc,
    input  logic [1:0]        if_id_ALUOp,
    input  logic [XLEN-1:0]   rs1_data,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [XLEN-1:0]   imm,
    output logic              id_ex_valid,
    output logic [XLEN-1:0]   id_ex_pc,
    output logic [XLEN-1:0]   id_ex_rs1_data,
    output logic [XLEN-1:0]   id_ex_rs2_data,
    output logic [XLEN-1:0]   id_ex_imm,
    output logic [REG_AW-1:0] id_ex_Rs1,
    output logic [REG_AW-1:0] id_ex_Rs2,
    output logic [REG_AW-1:0] id_ex_rd,
    output logic              id_ex_RegWrite,
    output logic              id_ex_MemRead,
    output logic              id_ex_MemWrite,
    output logic              id_ex_MemtoReg,
    output logic              id_ex_Branch,
    output logic              id_ex_ALUSrc,
    output logic [1:0]        id_ex_ALUOp,
`ifdef HAZARD_PERF_CNT_EN
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
`endif
    output logic              pc_write,
    output logic              if_id_write,
    output logic              hazard_stall
);

    logic lu;
    logic bubble;
    logic keep;

    assign lu = id_ex_valid & id_ex_MemRead & (id_ex_rd != '0) & if_id_valid &
                ((if_id_uses_rs1 & (if_id_Rs1 == id_ex_rd)) |
                 (if_id_uses_rs2 & (if_id_Rs2 == id_ex_rd)));

    assign bubble = ex_flush | lu;
    assign keep   = if_id_valid & ~bubble;

    // A flush lets the front end advance; only a genuine load-use holds PC and IF/ID.
    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        hazard_stall = 1'b0;
        if (ext_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (!ex_flush && lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            hazard_stall = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_ex_valid    <= 1'b0;
            id_ex_pc       <= '0;
            id_ex_rs1_data <= '0;
            id_ex_rs2_data <= '0;
            id_ex_imm      <= '0;
            id_ex_Rs1      <= '0;
            id_ex_Rs2      <= '0;
            id_ex_rd       <= '0;
            id_ex_RegWrite <= 1'b0;
            id_ex_MemRead  <= 1'b0;
            id_ex_MemWrite <= 1'b0;
            id_ex_MemtoReg <= 1'b0;
            id_ex_Branch   <= 1'b0;
            id_ex_ALUSrc   <= 1'b0;
            id_ex_ALUOp    <= 2'b00;
        end else if (!ext_stall) begin
            // Bubbles zero every field, so a squashed slot carries no stale data.
            id_ex_valid    <= keep;
            id_ex_pc       <= bubble ? '0 : if_id_pc;
            id_ex_rs1_data <= bubble ? '0 : rs1_data;
            id_ex_rs2_data <= bubble ? '0 : rs2_data;
            id_ex_imm      <= bubble ? '0 : imm;
            id_ex_Rs1      <= bubble ? '0 : if_id_Rs1;
            id_ex_Rs2      <= bubble ? '0 : if_id_Rs2;
            id_ex_rd       <= bubble ? '0 : if_id_rd;
            id_ex_RegWrite <= keep & if_id_RegWrite;
            id_ex_MemRead  <= keep & if_id_MemRead;
            id_ex_MemWrite <= keep & if_id_MemWrite;
            id_ex_MemtoReg <= keep & if_id_MemtoReg;
            id_ex_Branch   <= keep & if_id_Branch;
            id_ex_ALUSrc   <= keep & if_id_ALUSrc;
            id_ex_ALUOp    <= bubble ? 2'b00 : if_id_ALUOp;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else if (!ext_stall) begin
            if (ex_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end else if (lu) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Directed table-driven bench for id_ex_hazard_reg, plus a consecutive-flush sequence.
// Counter checks are compiled in when HAZARD_PERF_CNT_EN is defined.
module tb_id_ex_hazard_reg;

    localparam logic [5:0] RW   = 6'b100000;
    localparam logic [5:0] LD   = 6'b110101;
    localparam logic [5:0] ST   = 6'b001001;
    localparam logic [5:0] ALL  = 6'b111111;

    logic        clk = 1'b0;
    logic        rst_n, ext_stall, ex_flush, if_id_valid;
    logic [63:0] if_id_pc, rs1_data, rs2_data, imm;
    logic [4:0]  if_id_Rs1, if_id_Rs2, if_id_rd;
    logic        if_id_uses_rs1, if_id_uses_rs2;
    logic        if_id_RegWrite, if_id_MemRead, if_id_MemWrite, if_id_MemtoReg, if_id_Branch, if_id_ALUSrc;
    logic [1:0]  if_id_ALUOp;
    logic        id_ex_valid;
    logic [63:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
    logic [4:0]  id_ex_Rs1, id_ex_Rs2, id_ex_rd;
    logic        id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemtoReg, id_ex_Branch, id_ex_ALUSrc;
    logic [1:0]  id_ex_ALUOp;
    logic        pc_write, if_id_write, hazard_stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
`endif

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    id_ex_hazard_reg #(.XLEN(64), .REG_AW(5)) dut (
        .clk(clk), .rst_n(rst_n), .ext_stall(ext_stall), .ex_flush(ex_flush),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc),
        .if_id_Rs1(if_id_Rs1), .if_id_Rs2(if_id_Rs2), .if_id_rd(if_id_rd),
        .if_id_uses_rs1(if_id_uses_rs1), .if_id_uses_rs2(if_id_uses_rs2),
        .if_id_RegWrite(if_id_RegWrite), .if_id_MemRead(if_id_MemRead), .if_id_MemWrite(if_id_MemWrite),
        .if_id_MemtoReg(if_id_MemtoReg), .if_id_Branch(if_id_Branch), .if_id_ALUSrc(if_id_ALUSrc),
        .if_id_ALUOp(if_id_ALUOp), .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .id_ex_valid(id_ex_valid), .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data),
        .id_ex_rs2_data(id_ex_rs2_data), .id_ex_imm(id_ex_imm),
        .id_ex_Rs1(id_ex_Rs1), .id_ex_Rs2(id_ex_Rs2), .id_ex_rd(id_ex_rd),
        .id_ex_RegWrite(id_ex_RegWrite), .id_ex_MemRead(id_ex_MemRead), .id_ex_MemWrite(id_ex_MemWrite),
        .id_ex_MemtoReg(id_ex_MemtoReg), .id_ex_Branch(id_ex_Branch), .id_ex_ALUSrc(id_ex_ALUSrc),
        .id_ex_ALUOp(id_ex_ALUOp),
`ifdef HAZARD_PERF_CNT_EN
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
        .pc_write(pc_write), .if_id_write(if_id_write), .hazard_stall(hazard_stall)
    );

    typedef struct {
        logic        rst_n, ext_stall, ex_flush, valid;
        logic [63:0] pc;
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2;
        logic [5:0]  ctl;
        logic [1:0]  aluop;
        logic [2:0]  e_comb;
        logic        chk_comb;
        logic        e_valid;
        logic [63:0] e_pc;
        logic [4:0]  e_rs1, e_rs2, e_rd;
        logic [5:0]  e_ctl;
        logic [1:0]  e_aluop;
        logic [31:0] e_scnt, e_fcnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t v(input logic r, es, fl, val, input logic [63:0] pc,
                               input logic [4:0] rs1, rs2, rd, input logic u1, u2,
                               input logic [5:0] ctl, input logic [1:0] alu,
                               input logic [2:0] cmb, input logic chk,
                               input logic ev, input logic [63:0] epc,
                               input logic [4:0] ers1, ers2, erd,
                               input logic [5:0] ectl, input logic [1:0] ealu,
                               input logic [31:0] esc, efc);
        vec_t t;
        t.rst_n = r; t.ext_stall = es; t.ex_flush = fl; t.valid = val; t.pc = pc;
        t.rs1 = rs1; t.rs2 = rs2; t.rd = rd; t.u1 = u1; t.u2 = u2; t.ctl = ctl; t.aluop = alu;
        t.e_comb = cmb; t.chk_comb = chk; t.e_valid = ev; t.e_pc = epc;
        t.e_rs1 = ers1; t.e_rs2 = ers2; t.e_rd = erd; t.e_ctl = ectl; t.e_aluop = ealu;
        t.e_scnt = esc; t.e_fcnt = efc;
        return t;
    endfunction

    // Data operands are tied to the PC so captured data can be predicted from the expected PC.
    function automatic logic [63:0] d1(input logic [63:0] p); return p * 3;                endfunction
    function automatic logic [63:0] d2(input logic [63:0] p); return p << 4;               endfunction
    function automatic logic [63:0] d3(input logic [63:0] p); return {p[31:0], p[31:0]};   endfunction

    task automatic check_output(input string name, input int idx, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp)
            $display("[TB] FAIL %s step %0d: got %0h, expected %0h", name, idx, got, exp);
        else
            passed++;
    endtask

    task automatic apply_stimulus(input vec_t t);
        rst_n = t.rst_n; ext_stall = t.ext_stall; ex_flush = t.ex_flush; if_id_valid = t.valid;
        if_id_pc = t.pc; rs1_data = d1(t.pc); rs2_data = d2(t.pc); imm = d3(t.pc);
        if_id_Rs1 = t.rs1; if_id_Rs2 = t.rs2; if_id_rd = t.rd;
        if_id_uses_rs1 = t.u1; if_id_uses_rs2 = t.u2;
        {if_id_RegWrite, if_id_MemRead, if_id_MemWrite, if_id_MemtoReg, if_id_Branch, if_id_ALUSrc} = t.ctl;
        if_id_ALUOp = t.aluop;
    endtask

    task automatic check_regs(input int idx, input vec_t t);
        check_output("id_ex_valid", idx, 64'(id_ex_valid), 64'(t.e_valid));
        check_output("id_ex_pc", idx, id_ex_pc, t.e_pc);
        check_output("id_ex_rs1_data", idx, id_ex_rs1_data, d1(t.e_pc));
        check_output("id_ex_rs2_data", idx, id_ex_rs2_data, d2(t.e_pc));
        check_output("id_ex_imm", idx, id_ex_imm, d3(t.e_pc));
        check_output("id_ex_Rs1", idx, 64'(id_ex_Rs1), 64'(t.e_rs1));
        check_output("id_ex_Rs2", idx, 64'(id_ex_Rs2), 64'(t.e_rs2));
        check_output("id_ex_rd", idx, 64'(id_ex_rd), 64'(t.e_rd));
        check_output("id_ex_ctl", idx,
                     64'({id_ex_RegWrite, id_ex_MemRead, id_ex_MemWrite, id_ex_MemtoReg, id_ex_Branch, id_ex_ALUSrc}),
                     64'(t.e_ctl));
        check_output("id_ex_ALUOp", idx, 64'(id_ex_ALUOp), 64'(t.e_aluop));
`ifdef HAZARD_PERF_CNT_EN
        check_output("stall_cnt", idx, 64'(stall_cnt), 64'(t.e_scnt));
        check_output("flush_cnt", idx, 64'(flush_cnt), 64'(t.e_fcnt));
`endif
    endtask

    initial begin
        // rst ext flush valid pc rs1 rs2 rd u1 u2 ctl alu | comb{pcw,ifw,hz} chk | ev epc ers1 ers2 erd ectl ealu | scnt fcnt
        vecs.push_back(v(0,0,0,1,'h10,1,2,3,1,1,RW,2, 3'b110,0, 0,0,0,0,0,0,0, 0,0));
        vecs.push_back(v(0,0,0,1,'h10,1,2,3,1,1,RW,2, 3'b110,1, 0,0,0,0,0,0,0, 0,0));
        vecs.push_back(v(1,0,0,1,'h40,3,4,5,1,1,RW,2, 3'b110,1, 1,'h40,3,4,5,RW,2, 0,0));
        vecs.push_back(v(1,0,0,1,'h44,2,0,5,1,0,LD,0, 3'b110,1, 1,'h44,2,0,5,LD,0, 0,0));
        vecs.push_back(v(1,0,0,1,'h48,5,7,6,1,1,RW,2, 3'b001,1, 0,0,0,0,0,0,0, 1,0));
        vecs.push_back(v(1,0,0,1,'h48,5,7,6,1,1,RW,2, 3'b110,1, 1,'h48,5,7,6,RW,2, 1,0));
        vecs.push_back(v(1,0,0,1,'h4C,1,0,0,1,0,LD,0, 3'b110,1, 1,'h4C,1,0,0,LD,0, 1,0));
        vecs.push_back(v(1,0,0,1,'h50,0,0,8,1,1,RW,2, 3'b110,1, 1,'h50,0,0,8,RW,2, 1,0));
        vecs.push_back(v(1,0,0,1,'h54,2,0,5,1,0,LD,0, 3'b110,1, 1,'h54,2,0,5,LD,0, 1,0));
        vecs.push_back(v(1,0,0,1,'h58,9,5,0,1,0,ST,0, 3'b110,1, 1,'h58,9,5,0,ST,0, 1,0));
        vecs.push_back(v(1,0,0,1,'h5C,2,0,5,1,0,LD,0, 3'b110,1, 1,'h5C,2,0,5,LD,0, 1,0));
        vecs.push_back(v(1,0,1,1,'h60,5,7,6,1,1,RW,2, 3'b110,1, 0,0,0,0,0,0,0, 1,1));
        vecs.push_back(v(1,0,0,1,'h64,2,0,5,1,0,LD,0, 3'b110,1, 1,'h64,2,0,5,LD,0, 1,1));
        vecs.push_back(v(1,1,0,1,'h68,5,7,6,1,1,RW,2, 3'b000,1, 1,'h64,2,0,5,LD,0, 1,1));
        vecs.push_back(v(1,1,0,1,'h6C,1,1,1,1,1,RW,2, 3'b000,1, 1,'h64,2,0,5,LD,0, 1,1));
        vecs.push_back(v(1,1,1,1,'h70,5,7,6,1,1,RW,2, 3'b000,1, 1,'h64,2,0,5,LD,0, 1,1));
        vecs.push_back(v(1,0,0,1,'h74,3,5,9,1,1,RW,2, 3'b001,1, 0,0,0,0,0,0,0, 2,1));
        vecs.push_back(v(1,0,0,1,'h74,3,5,9,1,1,RW,2, 3'b110,1, 1,'h74,3,5,9,RW,2, 2,1));
        vecs.push_back(v(1,0,0,0,'h78,1,2,3,1,1,ALL,0,3'b110,1, 0,'h78,1,2,3,0,0, 2,1));
        vecs.push_back(v(1,0,0,0,'h7C,2,0,5,1,0,LD,0, 3'b110,1, 0,'h7C,2,0,5,0,0, 2,1));
        vecs.push_back(v(1,0,0,1,'h80,5,7,6,1,1,RW,2, 3'b110,1, 1,'h80,5,7,6,RW,2, 2,1));
        vecs.push_back(v(1,0,0,1,'h84,2,0,5,1,0,LD,0, 3'b110,1, 1,'h84,2,0,5,LD,0, 2,1));
        vecs.push_back(v(1,0,0,0,'h88,5,7,6,1,1,RW,0, 3'b110,1, 0,'h88,5,7,6,0,0, 2,1));
        vecs.push_back(v(1,0,0,1,'h8C,2,0,5,1,0,LD,0, 3'b110,1, 1,'h8C,2,0,5,LD,0, 2,1));
        vecs.push_back(v(0,1,0,1,'h90,5,7,6,1,1,RW,2, 3'b000,1, 0,0,0,0,0,0,0, 0,0));
        vecs.push_back(v(1,0,0,1,'h90,2,0,5,1,0,LD,0, 3'b110,1, 1,'h90,2,0,5,LD,0, 0,0));
        vecs.push_back(v(1,0,0,1,'h94,5,0,6,1,0,LD,0, 3'b001,1, 0,0,0,0,0,0,0, 1,0));
        vecs.push_back(v(1,0,0,1,'h94,5,0,6,1,0,LD,0, 3'b110,1, 1,'h94,5,0,6,LD,0, 1,0));
        vecs.push_back(v(1,0,0,1,'h98,6,5,7,1,1,RW,2, 3'b001,1, 0,0,0,0,0,0,0, 2,0));
        vecs.push_back(v(1,0,0,1,'h98,6,5,7,1,1,RW,2, 3'b110,1, 1,'h98,6,5,7,RW,2, 2,0));

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i]);
            #1;
            if (vecs[i].chk_comb) begin
                check_output("pc_write", i, 64'(pc_write), 64'(vecs[i].e_comb[2]));
                check_output("if_id_write", i, 64'(if_id_write), 64'(vecs[i].e_comb[1]));
                check_output("hazard_stall", i, 64'(hazard_stall), 64'(vecs[i].e_comb[0]));
            end
            @(posedge clk);
            #1;
            check_regs(i, vecs[i]);
        end

        // Three back-to-back flushes while a dependent load-use pattern sits in ID.
        apply_stimulus(v(1,0,0,1,'hA0,2,0,5,1,0,LD,0, 3'b110,1, 1,'hA0,2,0,5,LD,0, 0,0));
        @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            apply_stimulus(v(1,0,1,1,'hA4,5,0,6,1,0,RW,2, 3'b110,1, 0,0,0,0,0,0,0, 0,0));
            #1;
            check_output("flush_pc_write", 100 + k, 64'(pc_write), 64'd1);
            check_output("flush_hazard_stall", 100 + k, 64'(hazard_stall), 64'd0);
            @(posedge clk);
            #1;
            check_output("flush_valid", 100 + k, 64'(id_ex_valid), 64'd0);
            check_output("flush_RegWrite", 100 + k, 64'(id_ex_RegWrite), 64'd0);
`ifdef HAZARD_PERF_CNT_EN
            check_output("flush_cnt_seq", 100 + k, 64'(flush_cnt), 64'(k + 1));
            check_output("stall_cnt_seq", 100 + k, 64'(stall_cnt), 64'd2);
`endif
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
